// File: rtl/image_stream_feeder_pkg.sv
// ---------------------------------------------------------------------------
// image_stream_feeder_pkg
// Shared definitions for the image stream feeder:
//   - FSM state encoding
//   - default geometry / label-function constants
//   - small elaboration-time helpers (pixels per image, safe clog2)
// ---------------------------------------------------------------------------
package image_stream_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_DONE     = 2'd3
    } feeder_state_t;

    localparam int DEF_I_BW           = 8;
    localparam int DEF_IMG_W          = 28;
    localparam int DEF_IMG_H          = 28;
    localparam int DEF_N_IMG          = 100;

    // label(img_idx) = (img_idx / DEF_IMGS_PER_CLASS) % DEF_N_CLASS
    localparam int DEF_N_CLASS        = 10;
    localparam int DEF_IMGS_PER_CLASS = 10;

    function automatic int pix_per_img(input int w, input int h);
        return w * h;
    endfunction

    // Width of a counter that must hold 0..n-1, never below one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/image_stream_feeder_scoreboard.sv
// ---------------------------------------------------------------------------
// image_stream_feeder_scoreboard
// Latches the first classification result of each image, compares it with
// the label of the current image and keeps saturating correct / miss counts.
// The label is tracked incrementally (group counter + class counter) so no
// divider is needed.
//
// Ports:
//   clk, global_rst_n   clock, synchronous active-low reset
//   i_clear             run start: clear counters and label tracking
//   i_in_stream         FSM is streaming pixels
//   i_in_wait           FSM is waiting for a result
//   i_advance           network restart accepted, image finished
//   i_img_step          image index increments this cycle
//   i_result(_valid)    network class output and its strobe
//   o_correct_cnt       images classified correctly
//   o_miss_cnt          images restarted without a result
// ---------------------------------------------------------------------------
module image_stream_feeder_scoreboard
    import image_stream_feeder_pkg::*;
#(
    parameter int N_IMG          = DEF_N_IMG,
    parameter int N_CLASS        = DEF_N_CLASS,
    parameter int IMGS_PER_CLASS = DEF_IMGS_PER_CLASS
) (
    input  logic                         clk,
    input  logic                         global_rst_n,
    input  logic                         i_clear,
    input  logic                         i_in_stream,
    input  logic                         i_in_wait,
    input  logic                         i_advance,
    input  logic                         i_img_step,
    input  logic [$clog2(N_CLASS)-1:0]   i_result,
    input  logic                         i_result_valid,
    output logic [$clog2(N_IMG+1)-1:0]   o_correct_cnt,
    output logic [$clog2(N_IMG+1)-1:0]   o_miss_cnt
);

    localparam int RES_W = $clog2(N_CLASS);
    localparam int CNT_W = $clog2(N_IMG + 1);
    localparam int GRP_W = clog2_min1(IMGS_PER_CLASS);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(N_IMG);
    localparam logic [GRP_W-1:0] GRP_LAST  = GRP_W'(IMGS_PER_CLASS - 1);
    localparam logic [RES_W-1:0] CLS_LAST  = RES_W'(N_CLASS - 1);

    logic             got_res;
    logic [GRP_W-1:0] grp_cnt;
    logic [RES_W-1:0] label;
    logic             take;
    logic             hit;
    logic             miss;

    // A result arriving together with the restart is scored, not missed.
    always_comb begin
        take = i_in_wait && i_result_valid && !got_res;
        hit  = take && (i_result == label);
        miss = i_advance &&
               (i_in_stream || (i_in_wait && !got_res && !i_result_valid));
    end

    always_ff @(posedge clk) begin
        if (!global_rst_n) begin
            got_res       <= 1'b0;
            grp_cnt       <= '0;
            label         <= '0;
            o_correct_cnt <= '0;
            o_miss_cnt    <= '0;
        end else if (i_clear) begin
            got_res       <= 1'b0;
            grp_cnt       <= '0;
            label         <= '0;
            o_correct_cnt <= '0;
            o_miss_cnt    <= '0;
        end else begin
            if (i_advance) begin
                got_res <= 1'b0;
            end else if (take) begin
                got_res <= 1'b1;
            end
            if (hit && (o_correct_cnt != CNT_MAX)) begin
                o_correct_cnt <= o_correct_cnt + CNT_W'(1);
            end
            if (miss && (o_miss_cnt != CNT_MAX)) begin
                o_miss_cnt <= o_miss_cnt + CNT_W'(1);
            end
            if (i_img_step) begin
                if (grp_cnt == GRP_LAST) begin
                    grp_cnt <= '0;
                    label   <= (label == CLS_LAST) ? '0 : label + RES_W'(1);
                end else begin
                    grp_cnt <= grp_cnt + GRP_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/image_stream_feeder.sv
// ---------------------------------------------------------------------------
// image_stream_feeder
// Replays a bank of stored images into the lenet5 core, one pixel per
// network clock-enable, handles the per-image ce / restart handshake and
// (optionally) scores each classification against the image label.
//
// Optional feature macro: FEEDER_SCORE_EN
//   defined   -> scoreboard instantiated, o_correct_cnt / o_miss_cnt live
//   undefined -> scoring removed, both counters tied to zero
//
// Ports:
//   clk, global_rst_n   clock, synchronous active-low reset
//   i_start             begin a run (accepted in IDLE or DONE only)
//   o_mem_addr/o_mem_rd pixel read request; i_mem_data valid next cycle
//   i_mem_data          image memory read data
//   i_net_ce            network accepts a pixel this cycle
//   i_net_rst           network finished the image, ready for the next
//   i_result(_valid)    network class output and its strobe
//   o_fmap(_valid)      pixel to the network
//   o_img_idx           current image index
//   o_correct_cnt       correct classifications (saturating)
//   o_miss_cnt          images restarted without a result (saturating)
//   o_done              all images processed
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | after reset, waiting for i_start
// ST_STREAM   | issuing pixel reads on i_net_ce, raster order
// ST_WAIT_RES | all pixels issued, waiting for result / i_net_rst
// ST_DONE     | last image finished, counters held until i_start
// ---------------------------------------------------------------------------
module image_stream_feeder
    import image_stream_feeder_pkg::*;
#(
    parameter int I_BW           = DEF_I_BW,
    parameter int IMG_W          = DEF_IMG_W,
    parameter int IMG_H          = DEF_IMG_H,
    parameter int N_IMG          = DEF_N_IMG,
    parameter int N_CLASS        = DEF_N_CLASS,
    parameter int IMGS_PER_CLASS = DEF_IMGS_PER_CLASS,
    parameter int ADDR_W         = $clog2(N_IMG * pix_per_img(IMG_W, IMG_H))
) (
    input  logic                         clk,
    input  logic                         global_rst_n,
    input  logic                         i_start,
    output logic [ADDR_W-1:0]            o_mem_addr,
    output logic                         o_mem_rd,
    input  logic [I_BW-1:0]              i_mem_data,
    input  logic                         i_net_ce,
    input  logic                         i_net_rst,
    input  logic [$clog2(N_CLASS)-1:0]   i_result,
    input  logic                         i_result_valid,
    output logic [I_BW-1:0]              o_fmap,
    output logic                         o_fmap_valid,
    output logic [$clog2(N_IMG)-1:0]     o_img_idx,
    output logic [$clog2(N_IMG+1)-1:0]   o_correct_cnt,
    output logic [$clog2(N_IMG+1)-1:0]   o_miss_cnt,
    output logic                         o_done
);

    localparam int PIX_PER_IMG = pix_per_img(IMG_W, IMG_H);
    localparam int PIX_W       = $clog2(PIX_PER_IMG + 1);
    localparam int IDX_W       = $clog2(N_IMG);

    localparam logic [PIX_W-1:0]  PIX_N    = PIX_W'(PIX_PER_IMG);
    localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(PIX_PER_IMG - 1);
    localparam logic [IDX_W-1:0]  IMG_LAST = IDX_W'(N_IMG - 1);
    localparam logic [ADDR_W-1:0] IMG_STEP = ADDR_W'(PIX_PER_IMG);

    feeder_state_t     state;
    feeder_state_t     state_nxt;

    logic [PIX_W-1:0]  pix_idx;
    logic [ADDR_W-1:0] base_addr;
    logic              rd_d;

    logic              start_ok;
    logic              in_stream;
    logic              in_wait;
    logic              advance;
    logic              issue;
    logic              last_pix;
    logic              final_img;
    logic              img_step;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!global_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (i_start) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (advance)       state_nxt = final_img ? ST_DONE : ST_STREAM;
                else if (last_pix) state_nxt = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (advance) state_nxt = final_img ? ST_DONE : ST_STREAM;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM outputs ----------------
    // A restart in the same cycle as a ce wins: no read is issued for the
    // aborted image and the next image starts cleanly at pixel 0.
    always_comb begin
        in_stream = (state == ST_STREAM);
        in_wait   = (state == ST_WAIT_RES);
        start_ok  = i_start && ((state == ST_IDLE) || (state == ST_DONE));
        advance   = i_net_rst && (in_stream || in_wait);
        final_img = (o_img_idx == IMG_LAST);
        img_step  = advance && !final_img;
        issue     = in_stream && i_net_ce && !i_net_rst && (pix_idx < PIX_N);
        last_pix  = issue && (pix_idx == PIX_LAST);
        o_done    = (state == ST_DONE);
    end

    // ---------------- pixel datapath ----------------
    // Memory answers one cycle after o_mem_rd; rd_d marks the cycle in
    // which i_mem_data is valid, so o_fmap_valid trails the ce by two
    // cycles. The pipeline runs independently of the FSM so a read issued
    // just before a restart still reaches the network.
    always_ff @(posedge clk) begin
        if (!global_rst_n) begin
            o_mem_addr   <= '0;
            o_mem_rd     <= 1'b0;
            rd_d         <= 1'b0;
            o_fmap       <= '0;
            o_fmap_valid <= 1'b0;
            o_img_idx    <= '0;
            pix_idx      <= '0;
            base_addr    <= '0;
        end else begin
            o_mem_rd     <= issue;
            rd_d         <= o_mem_rd;
            o_fmap_valid <= rd_d;
            if (rd_d) begin
                o_fmap <= i_mem_data;
            end

            if (start_ok) begin
                o_img_idx  <= '0;
                pix_idx    <= '0;
                base_addr  <= '0;
                o_mem_addr <= '0;
            end else if (advance) begin
                pix_idx <= '0;
                if (img_step) begin
                    o_img_idx <= o_img_idx + IDX_W'(1);
                    base_addr <= base_addr + IMG_STEP;
                end
            end else if (issue) begin
                o_mem_addr <= base_addr + ADDR_W'(pix_idx);
                pix_idx    <= pix_idx + PIX_W'(1);
            end
        end
    end

    // ---------------- scoring ----------------
`ifdef FEEDER_SCORE_EN
    image_stream_feeder_scoreboard #(
        .N_IMG          (N_IMG),
        .N_CLASS        (N_CLASS),
        .IMGS_PER_CLASS (IMGS_PER_CLASS)
    ) u_scoreboard (
        .clk            (clk),
        .global_rst_n   (global_rst_n),
        .i_clear        (start_ok),
        .i_in_stream    (in_stream),
        .i_in_wait      (in_wait),
        .i_advance      (advance),
        .i_img_step     (img_step),
        .i_result       (i_result),
        .i_result_valid (i_result_valid),
        .o_correct_cnt  (o_correct_cnt),
        .o_miss_cnt     (o_miss_cnt)
    );
`else
    logic unused_score;
    assign unused_score  = ^{i_result, i_result_valid};
    assign o_correct_cnt = '0;
    assign o_miss_cnt    = '0;
`endif

endmodule

// File: tb/tb_image_stream_feeder.sv
// ---------------------------------------------------------------------------
// tb_image_stream_feeder
// Directed bench for image_stream_feeder. 20 images of 28x28 pixels,
// 2 images per label, 4 classes (labels wrap). Memory returns address LSBs.
// ---------------------------------------------------------------------------
module tb_image_stream_feeder;

    localparam int I_BW           = 8;
    localparam int IMG_W          = 28;
    localparam int IMG_H          = 28;
    localparam int N_IMG          = 20;
    localparam int N_CLASS        = 4;
    localparam int IMGS_PER_CLASS = 2;
    localparam int PIX            = IMG_W * IMG_H;
    localparam int ADDR_W         = $clog2(N_IMG * PIX);

`ifdef FEEDER_SCORE_EN
    localparam int SCORE = 1;
`else
    localparam int SCORE = 0;
`endif

    logic                         clk = 1'b0;
    logic                         global_rst_n = 1'b0;
    logic                         i_start = 1'b0;
    logic [ADDR_W-1:0]            o_mem_addr;
    logic                         o_mem_rd;
    logic [I_BW-1:0]              i_mem_data = '0;
    logic                         i_net_ce = 1'b0;
    logic                         i_net_rst = 1'b0;
    logic [$clog2(N_CLASS)-1:0]   i_result = '0;
    logic                         i_result_valid = 1'b0;
    logic [I_BW-1:0]              o_fmap;
    logic                         o_fmap_valid;
    logic [$clog2(N_IMG)-1:0]     o_img_idx;
    logic [$clog2(N_IMG+1)-1:0]   o_correct_cnt;
    logic [$clog2(N_IMG+1)-1:0]   o_miss_cnt;
    logic                         o_done;

    always #5 clk = ~clk;

    image_stream_feeder #(
        .I_BW           (I_BW),
        .IMG_W          (IMG_W),
        .IMG_H          (IMG_H),
        .N_IMG          (N_IMG),
        .N_CLASS        (N_CLASS),
        .IMGS_PER_CLASS (IMGS_PER_CLASS),
        .ADDR_W         (ADDR_W)
    ) dut (
        .clk            (clk),
        .global_rst_n   (global_rst_n),
        .i_start        (i_start),
        .o_mem_addr     (o_mem_addr),
        .o_mem_rd       (o_mem_rd),
        .i_mem_data     (i_mem_data),
        .i_net_ce       (i_net_ce),
        .i_net_rst      (i_net_rst),
        .i_result       (i_result),
        .i_result_valid (i_result_valid),
        .o_fmap         (o_fmap),
        .o_fmap_valid   (o_fmap_valid),
        .o_img_idx      (o_img_idx),
        .o_correct_cnt  (o_correct_cnt),
        .o_miss_cnt     (o_miss_cnt),
        .o_done         (o_done)
    );

    // image memory: data = address LSBs, one cycle latency
    always @(posedge clk) begin
        if (o_mem_rd) i_mem_data <= o_mem_addr[I_BW-1:0];
    end

    int n_chk  = 0;
    int n_pass = 0;

    int cyc = 0;
    int exp_addr = 0;
    int exp_fmap = 0;
    int rd_cnt = 0;
    int fmap_cnt = 0;
    int addr_err = 0;
    int fmap_err = 0;
    int first_valid_cyc = 0;
    int first_addr = 0;
    int last_addr = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int label_of(input int img);
        return (img / IMGS_PER_CLASS) % N_CLASS;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (o_fmap_valid) begin
            if (o_fmap !== I_BW'(exp_fmap)) fmap_err++;
            if (fmap_cnt == 0) first_valid_cyc = cyc;
            exp_fmap++;
            fmap_cnt++;
        end
        if (o_mem_rd) begin
            if (o_mem_addr !== ADDR_W'(exp_addr)) addr_err++;
            if (rd_cnt == 0) first_addr = int'(o_mem_addr);
            last_addr = int'(o_mem_addr);
            exp_addr++;
            rd_cnt++;
        end
    endtask

    task automatic mon_clear(input int base);
        exp_addr = base;
        exp_fmap = base;
        rd_cnt   = 0;
        fmap_cnt = 0;
    endtask

    // Stream one whole image. toggle: ce alternates 1/0. start_at: cycle
    // index at which a (to be ignored) i_start pulse is driven, -1 = none.
    task automatic stream_image(input int img, input bit toggle, input int start_at,
                                output int latency);
        int n;
        mon_clear(img * PIX);
        check("img_idx_at_start", o_img_idx, img);
        latency = -1;
        n = 0;
        while (rd_cnt < PIX && n < 4000) begin
            i_net_ce = toggle ? ((n % 2) == 0) : 1'b1;
            i_start  = (n == start_at);
            if (n == 0) latency = cyc + 1;
            tick();
            n++;
        end
        i_start  = 1'b0;
        i_net_ce = 1'b0;
        if (rd_cnt != PIX) check("stream_timeout", rd_cnt, PIX);
        repeat (3) tick();
        latency = first_valid_cyc - latency;
        check("fmap_count", fmap_cnt, PIX);
    endtask

    // kind 0: correct + restart together, 1: wrong class, 2: restart only,
    // 3: correct then a later wrong result (ignored), then restart
    task automatic finish_image(input int kind, input int img);
        int lbl;
        lbl = label_of(img);
        case (kind)
            0: begin
                i_result = 2'(lbl); i_result_valid = 1'b1; i_net_rst = 1'b1; tick();
            end
            1: begin
                i_result = 2'((lbl + 1) % N_CLASS); i_result_valid = 1'b1; i_net_rst = 1'b1; tick();
            end
            2: begin
                i_net_rst = 1'b1; tick();
            end
            default: begin
                i_result = 2'(lbl); i_result_valid = 1'b1; tick();
                i_result = 2'((lbl + 1) % N_CLASS); tick();
                i_result_valid = 1'b0; tick();
                i_net_rst = 1'b1; tick();
            end
        endcase
        i_result_valid = 1'b0;
        i_net_rst      = 1'b0;
    endtask

    initial begin
        int lat;
        int kind;

        // ---------------- reset ----------------
        repeat (2) tick();
        check("rst_mem_rd", o_mem_rd, 0);
        check("rst_mem_addr", o_mem_addr, 0);
        check("rst_fmap_valid", o_fmap_valid, 0);
        check("rst_img_idx", o_img_idx, 0);
        check("rst_done", o_done, 0);
        check("rst_counts", {o_correct_cnt, o_miss_cnt}, 0);
        global_rst_n = 1'b1;
        tick();

        // ce in IDLE must not read
        mon_clear(0);
        i_net_ce = 1'b1;
        repeat (3) tick();
        i_net_ce = 1'b0;
        check("idle_no_read", rd_cnt, 0);

        // ---------------- run A: all correct ----------------
        i_start = 1'b1; tick(); i_start = 1'b0;
        check("runA_done_clear", o_done, 0);

        stream_image(0, 1'b0, -1, lat);
        check("ce_to_valid_latency", lat, 2);
        check("img0_last_addr", last_addr, PIX - 1);
        finish_image(0, 0);

        stream_image(1, 1'b1, -1, lat);
        check("toggle_first_addr", first_addr, PIX);
        check("toggle_last_addr", last_addr, 2 * PIX - 1);
        check("toggle_rd_count", rd_cnt, PIX);
        finish_image(0, 1);

        for (int img = 2; img < N_IMG; img++) begin
            check("runA_not_done", o_done, 0);
            stream_image(img, 1'b0, -1, lat);
            finish_image(0, img);
        end
        check("runA_done", o_done, 1);
        check("runA_img_idx", o_img_idx, N_IMG - 1);
        check("runA_correct", o_correct_cnt, SCORE * N_IMG);
        check("runA_miss", o_miss_cnt, 0);
        check("runA_addr_err", addr_err, 0);
        check("runA_fmap_err", fmap_err, 0);

        // DONE holds and issues no reads
        mon_clear(0);
        i_net_ce = 1'b1;
        repeat (5) tick();
        i_net_ce = 1'b0;
        check("done_no_read", rd_cnt, 0);
        check("done_hold", o_done, 1);
        check("done_hold_correct", o_correct_cnt, SCORE * N_IMG);

        // ---------------- run B: abort, wrong, no result ----------------
        i_start = 1'b1; tick(); i_start = 1'b0;
        check("runB_done_clear", o_done, 0);
        check("runB_correct_clear", o_correct_cnt, 0);
        check("runB_img_clear", o_img_idx, 0);

        mon_clear(0);
        i_net_ce = 1'b1;
        for (int n = 0; n < 1000 && rd_cnt < 300; n++) tick();
        i_net_ce  = 1'b0;
        i_net_rst = 1'b1;
        tick();
        i_net_rst = 1'b0;
        repeat (3) tick();
        check("abort_inflight_fmap", fmap_cnt, 300);
        check("abort_miss", o_miss_cnt, SCORE * 1);
        check("abort_img_idx", o_img_idx, 1);

        for (int img = 1; img < N_IMG; img++) begin
            stream_image(img, 1'b0, (img == 3) ? 50 : -1, lat);
            if (img == 1) check("after_abort_addr", first_addr, PIX);
            if (img == 3) check("start_ignored", o_img_idx, 3);
            kind = (img == 5) ? 1 : (img == 7) ? 2 : (img == 9) ? 3 : 0;
            finish_image(kind, img);
            if (img == 5) check("wrong_not_counted", o_correct_cnt, SCORE * 4);
            if (img == 7) check("noresult_miss", o_miss_cnt, SCORE * 2);
        end
        check("runB_done", o_done, 1);
        check("runB_correct", o_correct_cnt, SCORE * 17);
        check("runB_miss", o_miss_cnt, SCORE * 2);
        check("runB_addr_err", addr_err, 0);
        check("runB_fmap_err", fmap_err, 0);

        // ---------------- run C: reset mid image 3 ----------------
        i_start = 1'b1; tick(); i_start = 1'b0;
        for (int img = 0; img < 3; img++) begin
            stream_image(img, 1'b0, -1, lat);
            finish_image(0, img);
        end
        check("runC_img3", o_img_idx, 3);
        mon_clear(3 * PIX);
        i_net_ce = 1'b1;
        repeat (100) tick();
        global_rst_n = 1'b0;
        tick();
        i_net_ce = 1'b0;
        check("midrst_mem_rd", o_mem_rd, 0);
        check("midrst_mem_addr", o_mem_addr, 0);
        check("midrst_fmap_valid", o_fmap_valid, 0);
        check("midrst_fmap", o_fmap, 0);
        check("midrst_img_idx", o_img_idx, 0);
        check("midrst_counts", {o_correct_cnt, o_miss_cnt}, 0);
        check("midrst_done", o_done, 0);
        global_rst_n = 1'b1;
        tick();
        i_start = 1'b1; tick(); i_start = 1'b0;
        mon_clear(0);
        i_net_ce = 1'b1;
        tick();
        i_net_ce = 1'b0;
        check("restart_rd", o_mem_rd, 1);
        check("restart_addr", o_mem_addr, 0);
        repeat (2) tick();
        check("restart_fmap_valid", o_fmap_valid, 1);
        check("restart_fmap", o_fmap, 0);
        check("final_addr_err", addr_err, 0);
        check("final_fmap_err", fmap_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
